// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data SRAM: grants one request per cycle,
// rejects accesses outside the SRAM window and routes the 1-cycle response to the granted port.
module dmem_port_arbiter #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned RAM_SIZE       = 32768,
   parameter int unsigned MEM_ADDR_WIDTH = $clog2(RAM_SIZE),
   parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
   parameter bit          FIXED_PRIO     = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_ni,

   input  logic                      p0_req_i,
   output logic                      p0_gnt_o,
   input  logic [31:0]               p0_addr_i,
   input  logic                      p0_we_i,
   input  logic [DATA_WIDTH/8-1:0]   p0_be_i,
   input  logic [DATA_WIDTH-1:0]     p0_wdata_i,
   output logic                      p0_rvalid_o,
   output logic [DATA_WIDTH-1:0]     p0_rdata_o,
   output logic                      p0_err_o,

   input  logic                      p1_req_i,
   output logic                      p1_gnt_o,
   input  logic [31:0]               p1_addr_i,
   input  logic                      p1_we_i,
   input  logic [DATA_WIDTH/8-1:0]   p1_be_i,
   input  logic [DATA_WIDTH-1:0]     p1_wdata_i,
   output logic                      p1_rvalid_o,
   output logic [DATA_WIDTH-1:0]     p1_rdata_o,
   output logic                      p1_err_o,

   output logic                      mem_en_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic                      mem_we_o,
   output logic [DATA_WIDTH/8-1:0]   mem_be_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

   localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] WIN_HI = WIN_LO + 33'(RAM_SIZE);

   logic                    rr_ptr;
   logic                    resp_valid;
   logic                    resp_port;
   logic                    resp_err;
   logic                    resp_we;

   logic                    grant;
   logic                    winner;
   logic                    in_win;
   logic [31:0]             win_addr;
   logic                    win_we;
   logic [DATA_WIDTH/8-1:0] win_be;
   logic [DATA_WIDTH-1:0]   win_wdata;

   always_comb begin
      grant = (p0_req_i | p1_req_i) & rst_ni;
      // a sole requester (or nobody) resolves to p1_req_i; only a tie consults the policy
      if (p0_req_i && p1_req_i) begin
         winner = FIXED_PRIO ? 1'b0 : rr_ptr;
      end else begin
         winner = p1_req_i;
      end
      win_addr  = winner ? p1_addr_i  : p0_addr_i;
      win_we    = winner ? p1_we_i    : p0_we_i;
      win_be    = winner ? p1_be_i    : p0_be_i;
      win_wdata = winner ? p1_wdata_i : p0_wdata_i;
      in_win    = ({1'b0, win_addr} >= WIN_LO) && ({1'b0, win_addr} < WIN_HI);
   end

   assign p0_gnt_o = grant & ~winner;
   assign p1_gnt_o = grant & winner;

   assign mem_en_o    = grant & in_win;
   assign mem_we_o    = mem_en_o & win_we;
   assign mem_be_o    = mem_en_o ? win_be : '0;
   assign mem_wdata_o = mem_en_o ? win_wdata : '0;
   // low bits of the offset only; BASE_ADDR alignment makes the upper borrow irrelevant
   assign mem_addr_o  = mem_en_o ?
                        {win_addr[MEM_ADDR_WIDTH-1:2] - BASE_ADDR[MEM_ADDR_WIDTH-1:2], 2'b00} : '0;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr     <= 1'b0;
         resp_valid <= 1'b0;
         resp_port  <= 1'b0;
         resp_err   <= 1'b0;
         resp_we    <= 1'b0;
      end else begin
         resp_valid <= grant;
         if (grant) begin
            rr_ptr    <= ~winner;
            resp_port <= winner;
            resp_err  <= ~in_win;
            resp_we   <= win_we;
         end
      end
   end

   assign p0_rvalid_o = resp_valid & ~resp_port;
   assign p1_rvalid_o = resp_valid & resp_port;
   assign p0_err_o    = p0_rvalid_o & resp_err;
   assign p1_err_o    = p1_rvalid_o & resp_err;
   assign p0_rdata_o  = (p0_rvalid_o & ~resp_err & ~resp_we) ? mem_rdata_i : '0;
   assign p1_rdata_o  = (p1_rvalid_o & ~resp_err & ~resp_we) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a round-robin and a fixed-priority instance share one stimulus
// stream; each has its own SRAM model and is compared with a transaction-level reference.
module tb_dmem_port_arbiter;

   localparam logic [31:0] BASE  = 32'h0010_0000;
   localparam int unsigned RSIZE = 32768;
   localparam int unsigned WORDS = RSIZE / 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        clr_mem;
   logic        p0_req, p1_req, p0_we, p1_we;
   logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic [3:0]  p0_be, p1_be;

   logic        gnt0 [2], gnt1 [2], rv0 [2], rv1 [2], er0 [2], er1 [2], men [2], mwe [2];
   logic [31:0] rd0 [2], rd1 [2], mwd [2], mrd [2];
   logic [14:0] mad [2];
   logic [3:0]  mbe [2];
   logic [31:0] sram [2][WORDS];

   for (genvar k = 0; k < 2; k++) begin : g_dut
      dmem_port_arbiter #(.FIXED_PRIO(k == 1)) u_dut (
         .clk(clk), .rst_ni(rst_n),
         .p0_req_i(p0_req), .p0_gnt_o(gnt0[k]), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
         .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(rv0[k]), .p0_rdata_o(rd0[k]),
         .p0_err_o(er0[k]),
         .p1_req_i(p1_req), .p1_gnt_o(gnt1[k]), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
         .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(rv1[k]), .p1_rdata_o(rd1[k]),
         .p1_err_o(er1[k]),
         .mem_en_o(men[k]), .mem_addr_o(mad[k]), .mem_we_o(mwe[k]), .mem_be_o(mbe[k]),
         .mem_wdata_o(mwd[k]), .mem_rdata_i(mrd[k])
      );
   end

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (clr_mem) begin
            for (int j = 0; j < WORDS; j++) sram[k][j] <= '0;
         end else if (men[k]) begin
            if (mwe[k]) begin
               for (int b = 0; b < 4; b++)
                  if (mbe[k][b]) sram[k][mad[k][14:2]][8*b +: 8] <= mwd[k][8*b +: 8];
            end else begin
               mrd[k] <= sram[k][mad[k][14:2]];
            end
         end
      end
   end

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   bit          m_pref [2] = '{1'b0, 1'b0};
   bit          m_rv [2]   = '{1'b0, 1'b0};
   bit          m_rport [2];
   bit          m_rerr [2];
   logic [31:0] m_rdata [2];
   logic [31:0] ref_mem [2][WORDS];

   function automatic bit in_win(logic [31:0] a);
      longint unsigned x;
      x = {32'd0, a};
      return (x >= 64'h0010_0000) && (x < 64'h0010_0000 + 64'(RSIZE));
   endfunction

   // port the reference expects to win on instance k (1 = fixed priority), -1 if none
   function automatic int exp_win(int k);
      if (!rst_n || (!p0_req && !p1_req)) return -1;
      if (p0_req && p1_req) return (k == 1) ? 0 : int'(m_pref[k]);
      return p0_req ? 0 : 1;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0: a = 32'h0000_0000;
         1: a = 32'h0010_8000 + 32'($urandom_range(0, 3));
         2: a = 32'h000F_FFFC + 32'($urandom_range(0, 3));
         3: a = 32'h0010_7FFC + 32'($urandom_range(0, 3));
         4: a = $urandom;
         default: a = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      endcase
      return a;
   endfunction

   task automatic tick();
      int          w;
      logic [31:0] a, wd;
      logic        we;
      logic [3:0]  be;
      int unsigned idx;
      @(posedge clk);
      n_vec++;
      for (int k = 0; k < 2; k++) begin
         w = exp_win(k);
         if (!rst_n) begin
            m_pref[k] = 1'b0;
            m_rv[k]   = 1'b0;
         end else if (w < 0) begin
            m_rv[k] = 1'b0;
         end else begin
            a  = (w == 1) ? p1_addr  : p0_addr;
            we = (w == 1) ? p1_we    : p0_we;
            be = (w == 1) ? p1_be    : p0_be;
            wd = (w == 1) ? p1_wdata : p0_wdata;
            idx = ((a - BASE) >> 2) & (WORDS - 1);
            m_rv[k]    = 1'b1;
            m_rport[k] = (w == 1);
            m_rerr[k]  = !in_win(a);
            m_rdata[k] = (in_win(a) && !we) ? ref_mem[k][idx] : 32'h0;
            if (in_win(a) && we)
               for (int b = 0; b < 4; b++) if (be[b]) ref_mem[k][idx][8*b +: 8] = wd[8*b +: 8];
            m_pref[k] = (w == 0);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr_mem = 1'b1;
      p0_req = 1'b1; p0_addr = BASE; p0_we = 1'b0; p0_be = 4'hF; p0_wdata = '0;
      p1_req = 1'b0; p1_addr = BASE; p1_we = 1'b0; p1_be = 4'hF; p1_wdata = '0;
      tick();
      clr_mem = 1'b0;
      tick();
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         if ({gnt0[k], gnt1[k], rv0[k], rv1[k], er0[k], er1[k], men[k]} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs[%0d]: got %b expected 0000000", k,
                     {gnt0[k], gnt1[k], rv0[k], rv1[k], er0[k], er1[k], men[k]});
         end
      #2 rst_n = 1'b1;
      #1;
      for (int k = 0; k < 2; k++)
         if (gnt0[k] !== 1'b1 || gnt1[k] !== 1'b0) begin
            n_err++;
            $display("FAIL release_gnt[%0d]: got %b%b expected 10", k, gnt0[k], gnt1[k]);
         end
      tick();
      p0_req = 1'b0;
   endtask

   task automatic test_single_read();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h0010_0010; p0_be = 4'hF; p0_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         if ({gnt0[k], men[k], mwe[k], mbe[k], mad[k], mwd[k]} !==
             {1'b1, 1'b1, 1'b1, 4'hF, 15'h0010, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL write_req[%0d]: gnt=%b en=%b we=%b be=%h addr=%h wdata=%h expected 1 1 1 f 0010 deadbeef",
                     k, gnt0[k], men[k], mwe[k], mbe[k], mad[k], mwd[k]);
         end
      tick();
      p0_we = 1'b0; p0_wdata = '0;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         if ({gnt0[k], mwe[k], rv0[k], er0[k], rd0[k]} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL write_resp[%0d]: gnt=%b we=%b rvalid=%b err=%b rdata=%h expected 1 0 1 0 0",
                     k, gnt0[k], mwe[k], rv0[k], er0[k], rd0[k]);
         end
      tick();
      p0_req = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         if ({rv0[k], er0[k], rv1[k], rd0[k]} !== {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL read_resp[%0d]: rvalid=%b err=%b p1_rvalid=%b rdata=%h expected 1 0 0 deadbeef",
                     k, rv0[k], er0[k], rv1[k], rd0[k]);
         end
      tick();
   endtask

   task automatic test_round_robin();
      int exp_rr [4] = '{0, 1, 0, 1};
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = BASE + 32'h20; p1_be = 4'hF; p1_wdata = 32'h1234_5678;
      tick();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = BASE + 32'h10; p1_we = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin p0_req = 1'b0; p1_req = 1'b0; end
         @(negedge clk);
         if (i < 4) begin
            if (gnt0[0] !== (exp_rr[i] == 0) || gnt1[0] !== (exp_rr[i] == 1)) begin
               n_err++;
               $display("FAIL rr_gnt[%0d]: got %b%b expected port %0d", i, gnt0[0], gnt1[0], exp_rr[i]);
            end
            if (gnt0[1] !== 1'b1 || gnt1[1] !== 1'b0) begin
               n_err++;
               $display("FAIL fixed_gnt[%0d]: got %b%b expected 10", i, gnt0[1], gnt1[1]);
            end
         end
         if (i > 0) begin
            if (rv0[0] !== (exp_rr[i-1] == 0) || rv1[0] !== (exp_rr[i-1] == 1) ||
                rd0[0] !== ((exp_rr[i-1] == 0) ? 32'hDEAD_BEEF : 32'h0) ||
                rd1[0] !== ((exp_rr[i-1] == 1) ? 32'h1234_5678 : 32'h0)) begin
               n_err++;
               $display("FAIL rr_resp[%0d]: rv=%b%b rd0=%h rd1=%h expected response on port %0d",
                        i, rv0[0], rv1[0], rd0[0], rd1[0], exp_rr[i-1]);
            end
         end
         tick();
      end
   endtask

   task automatic test_fixed_prio();
      p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
      p0_addr = BASE + 32'h10; p1_addr = BASE + 32'h20;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) p0_req = 1'b0;
         @(negedge clk);
         if (gnt0[1] !== (i < 3) || gnt1[1] !== (i == 3)) begin
            n_err++;
            $display("FAIL fixed_prio[%0d]: got %b%b expected %b%b", i, gnt0[1], gnt1[1], i < 3, i == 3);
         end
         if (gnt0[0] !== (exp_win(0) == 0) || gnt1[0] !== (exp_win(0) == 1)) begin
            n_err++;
            $display("FAIL rr_tie[%0d]: got %b%b expected port %0d", i, gnt0[0], gnt1[0], exp_win(0));
         end
         tick();
      end
      p1_req = 1'b0;
   endtask

   task automatic test_window();
      logic [31:0] addrs [5] = '{32'h0000_0000, 32'h0010_8000, 32'h0010_7FFC, 32'h000F_FFFC, 32'hFFFF_FFFC};
      bit          inw [5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      p0_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         p1_req = 1'b1; p1_we = 1'b0; p1_addr = addrs[i];
         @(negedge clk);
         for (int k = 0; k < 2; k++)
            if (gnt1[k] !== 1'b1 || men[k] !== inw[i] || mad[k] !== (inw[i] ? 15'h7FFC : 15'h0)) begin
               n_err++;
               $display("FAIL window_req[%0d.%0d]: gnt=%b en=%b addr=%h for %h", i, k,
                        gnt1[k], men[k], mad[k], addrs[i]);
            end
         tick();
         p1_req = 1'b0;
         @(negedge clk);
         for (int k = 0; k < 2; k++)
            if (rv1[k] !== 1'b1 || er1[k] !== !inw[i] ||
                rd1[k] !== (inw[i] ? ref_mem[k][WORDS-1] : 32'h0)) begin
               n_err++;
               $display("FAIL window_resp[%0d.%0d]: rvalid=%b err=%b rdata=%h expected err=%b", i, k,
                        rv1[k], er1[k], rd1[k], !inw[i]);
            end
         tick();
      end
   endtask

   task automatic test_mid_reset();
      p1_req = 1'b0; p0_req = 1'b1; p0_we = 1'b0; p0_addr = BASE;
      tick();
      p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b0; p1_addr = BASE + 32'h20;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         if (gnt1[k] !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_gnt[%0d]: got %b expected 1", k, gnt1[k]);
         end
      #2 rst_n = 1'b0;
      tick();
      p1_req = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         if (rv1[k] !== 1'b0 || rv0[k] !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_rvalid[%0d]: got %b%b expected 00", k, rv0[k], rv1[k]);
         end
      #2 rst_n = 1'b1;
      p0_req = 1'b1; p1_req = 1'b1;
      #1;
      for (int k = 0; k < 2; k++)
         if (gnt0[k] !== 1'b1 || gnt1[k] !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_prio[%0d]: got %b%b expected 10", k, gnt0[k], gnt1[k]);
         end
      tick();
      p0_req = 1'b0; p1_req = 1'b0;
   endtask

   task automatic test_random();
      int          w;
      logic [31:0] ea, ewd;
      logic        ewe, een, erv0, erv1;
      logic [3:0]  ebe;
      for (int n = 0; n < 600; n++) begin
         p0_req = ($urandom_range(0, 3) != 0); p1_req = ($urandom_range(0, 3) != 0);
         p0_we = $urandom_range(0, 1); p1_we = $urandom_range(0, 1);
         p0_be = 4'($urandom); p1_be = 4'($urandom);
         p0_wdata = $urandom; p1_wdata = $urandom;
         p0_addr = rand_addr(); p1_addr = rand_addr();
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            w    = exp_win(k);
            ea   = (w == 1) ? p1_addr  : p0_addr;
            ewe  = (w == 1) ? p1_we    : p0_we;
            ebe  = (w == 1) ? p1_be    : p0_be;
            ewd  = (w == 1) ? p1_wdata : p0_wdata;
            een  = (w >= 0) && in_win(ea);
            erv0 = m_rv[k] && !m_rport[k];
            erv1 = m_rv[k] && m_rport[k];
            if (gnt0[k] !== (w == 0) || gnt1[k] !== (w == 1)) begin
               n_err++;
               $display("FAIL rnd_gnt[%0d.%0d]: got %b%b expected winner %0d", n, k, gnt0[k], gnt1[k], w);
            end
            if ({men[k], mwe[k], mbe[k], mwd[k], mad[k]} !==
                (een ? {1'b1, ewe, ebe, ewd, 15'((ea - BASE) & 32'h7FFC)} : 53'h0)) begin
               n_err++;
               $display("FAIL rnd_mem[%0d.%0d]: en=%b we=%b be=%h wd=%h addr=%h for addr %h en_exp=%b",
                        n, k, men[k], mwe[k], mbe[k], mwd[k], mad[k], ea, een);
            end
            if ({rv0[k], rv1[k], er0[k], er1[k]} !==
                {erv0, erv1, erv0 && m_rerr[k], erv1 && m_rerr[k]}) begin
               n_err++;
               $display("FAIL rnd_resp[%0d.%0d]: rv=%b%b err=%b%b expected rv=%b%b err=%b", n, k,
                        rv0[k], rv1[k], er0[k], er1[k], erv0, erv1, m_rerr[k]);
            end
            if (rd0[k] !== (erv0 ? m_rdata[k] : 32'h0) || rd1[k] !== (erv1 ? m_rdata[k] : 32'h0)) begin
               n_err++;
               $display("FAIL rnd_rdata[%0d.%0d]: got %h/%h expected %h on port %b", n, k,
                        rd0[k], rd1[k], m_rdata[k], m_rport[k]);
            end
         end
         tick();
      end
      p0_req = 1'b0; p1_req = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < WORDS; j++) ref_mem[k][j] = '0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_prio();
      test_window();
      test_mid_reset();
      test_random();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
